// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, NOP, fetch FSM states and IF/ID record shared by the RV32I pipeline
package riscv_pkg;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] HALT   = 7'b0000001;
  localparam logic [6:0] U_TYPE = 7'b0110111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
endpackage

// File: rtl/if_halt_fsm.sv
// if_halt_fsm: HALT drain sequencer (RUN -> DRAIN -> HALTED), cancelled by branch_taken
module if_halt_fsm
  import riscv_pkg::*;
#(
  parameter int HALT_DRAIN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [6:0]   opcode,
  output fetch_state_t state,
  output logic         halted
);
  fetch_state_t state_n;
  logic [3:0] cnt, cnt_n;
  logic halted_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      halted <= halted_n;
    end
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    halted_n = halted;
    if (branch_taken) begin
      state_n  = RUN;
      cnt_n    = '0;
      halted_n = 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: if (opcode == HALT) begin
          state_n = DRAIN;
          cnt_n   = 4'(HALT_DRAIN - 1);
        end
        DRAIN: if (cnt == '0) begin
          state_n  = HALTED;
          halted_n = 1'b1;
        end else cnt_n = cnt - 4'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage owning the PC and the IF/ID register.
// Define IF_PERF_CNT_EN to add saturating fetch_count/bubble_count outputs.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_AW    = 9,
  parameter int          HALT_DRAIN = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_out,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_instr,
  output logic               ifid_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count,
`endif
  output logic               halted
);
  fetch_state_t state;
  ifid_t ifid;
  logic [31:0] pc;
  if_halt_fsm #(.HALT_DRAIN(HALT_DRAIN)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .opcode       (imem_rdata[6:0]),
    .state        (state),
    .halted       (halted)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc   <= RESET_PC & ~32'h3;
      ifid <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (branch_taken) begin
      pc         <= branch_target & ~32'h3;
      ifid.instr <= NOP_INSTR;
      ifid.valid <= 1'b0;
    end else if (!stall) begin
      if (state == RUN) begin
        ifid <= '{pc: pc, instr: imem_rdata, valid: 1'b1};
        pc   <= imem_rdata[6:0] == HALT ? pc : pc + 32'd4;
      end else begin
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end
    end
  end
  assign imem_addr  = pc[IMEM_AW+1:2];
  assign pc_out     = pc;
  assign ifid_pc    = ifid.pc;
  assign ifid_instr = ifid.instr;
  assign ifid_valid = ifid.valid;
`ifdef IF_PERF_CNT_EN
  logic loads_valid, loads_bubble;
  assign loads_valid  = !branch_taken && !stall && state == RUN;
  assign loads_bubble = branch_taken || (!stall && state != RUN);
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (loads_valid && !(&fetch_count)) fetch_count <= fetch_count + 32'd1;
      if (loads_bubble && !(&bubble_count)) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus against a cycle-level fetch model plus literal checkpoints
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DRAIN_N = 3;
  logic clk = 1'b0, reset, stall, branch_taken;
  logic [31:0] branch_target, imem_rdata, pc_out, ifid_pc, ifid_instr;
  logic [8:0] imem_addr, imem_addr_w;
  logic ifid_valid, halted;
  logic [31:0] rdata_w, pc_w, ifid_pc_w, ifid_instr_w;
  logic valid_w, halted_w;
  logic [31:0] mem [512];
  int n_chk = 0, n_fail = 0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count, fc_w, bc_w;
  longint m_fc, m_bc;
`endif
  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];
  assign rdata_w    = mem[imem_addr_w];

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .halted(halted)
  );
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr_w), .imem_rdata(rdata_w),
    .pc_out(pc_w), .ifid_pc(ifid_pc_w), .ifid_instr(ifid_instr_w), .ifid_valid(valid_w),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fc_w), .bubble_count(bc_w),
`endif
    .halted(halted_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pc, IF/ID contents, and a count of bubbles still owed before halting
  logic [31:0] m_pc, m_ipc, m_instr;
  logic m_valid, m_halted, m_started = 1'b0;
  int m_owed;
  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_halted = 1'b0; m_owed = 0; m_started = 1'b1;
`ifdef IF_PERF_CNT_EN
      m_fc = 0; m_bc = 0;
`endif
    end else if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
      m_halted = 1'b0; m_owed = 0;
`ifdef IF_PERF_CNT_EN
      m_bc = m_bc + 1;
`endif
    end else if (!stall) begin
      if (m_owed > 0 || m_halted) begin
        m_instr = NOP; m_valid = 1'b0;
        if (m_owed > 0) begin
          m_owed--;
          if (m_owed == 0) m_halted = 1'b1;
        end
`ifdef IF_PERF_CNT_EN
        m_bc = m_bc + 1;
`endif
      end else begin
        m_ipc = m_pc; m_instr = mem[m_pc[10:2]]; m_valid = 1'b1;
        if (m_instr[6:0] == 7'b0000001) m_owed = DRAIN_N;
        else m_pc = m_pc + 32'd4;
`ifdef IF_PERF_CNT_EN
        m_fc = m_fc + 1;
`endif
      end
    end
  end

  always @(negedge clk) if (m_started) begin
    chk("pc_out", pc_out, m_pc);
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[10:2]));
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
`ifdef IF_PERF_CNT_EN
    chk("fetch_count", fetch_count, 32'(m_fc));
    chk("bubble_count", bubble_count, 32'(m_bc));
`endif
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_ifid_pc"}, ifid_pc, 32'h0);
    chk({tag, "_instr"}, ifid_instr, NOP);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = NOP;
    mem[0]   = 32'h0050_0093;
    mem[1]   = 32'h00A0_0113;
    mem[2]   = 32'h0030_0193;
    mem[3]   = 32'h0000_0001;
    mem[8]   = 32'h0020_0293;
    mem[16]  = 32'h0010_0213;
    mem[18]  = 32'h0000_0001;
    mem[511] = 32'h0070_0393;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    step(2);
    chk_reset_state("rst");
    chk("wrap_rst_pc", pc_w, 32'hFFFF_FFFC);
    reset = 1'b1;
    step();
    chk("seq0_pc", ifid_pc, 32'h0);
    chk("seq0_instr", ifid_instr, 32'h0050_0093);
    chk("seq0_valid", 32'(ifid_valid), 32'h1);
    chk("wrap_pc", pc_w, 32'h0);
    chk("wrap_ifid_pc", ifid_pc_w, 32'hFFFF_FFFC);
    chk("wrap_instr", ifid_instr_w, 32'h0070_0393);
    step();
    chk("seq1_pc", ifid_pc, 32'h4);
    chk("seq1_instr", ifid_instr, 32'h00A0_0113);
    chk("seq1_pcout", pc_out, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_addr", 32'(imem_addr), 32'h2);
      chk("stall_instr", ifid_instr, 32'h00A0_0113);
    end
    stall = 1'b0;
    step();
    chk("resume_pc", ifid_pc, 32'h8);
    chk("resume_instr", ifid_instr, 32'h0030_0193);
    step();
    chk("halt_instr", ifid_instr, 32'h0000_0001);
    chk("halt_valid", 32'(ifid_valid), 32'h1);
    chk("halt_pc", pc_out, 32'hC);
    step(2);
    chk("drain2_halted", 32'(halted), 32'h0);
    chk("drain2_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("drain3_halted", 32'(halted), 32'h1);
    step(3);
    chk("halted_pc", pc_out, 32'hC);
    chk("halted_hold", 32'(halted), 32'h1);
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    branch_taken = 1'b0;
    chk("unhalt_halted", 32'(halted), 32'h0);
    chk("unhalt_pc", pc_out, 32'h20);
    step();
    chk("unhalt_fetch", ifid_instr, 32'h0020_0293);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h43;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    chk("brstall_pc", pc_out, 32'h40);
    chk("brstall_valid", 32'(ifid_valid), 32'h0);
    chk("brstall_instr", ifid_instr, NOP);
    step();
    chk("brstall_fetch_pc", ifid_pc, 32'h40);
    chk("brstall_fetch", ifid_instr, 32'h0010_0213);
    step(2);
    chk("halt2_instr", ifid_instr, 32'h0000_0001);
    step();
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    branch_taken = 1'b0;
    chk("cancel_pc", pc_out, 32'h20);
    step(6);
    chk("cancel_halted", 32'(halted), 32'h0);
    branch_taken = 1'b1; branch_target = 32'h48;
    step();
    branch_taken = 1'b0;
    step(2);
    reset = 1'b0;
    step();
    chk_reset_state("midrst");
    reset = 1'b1;
    step();
    chk("post_rst_pc", ifid_pc, 32'h0);
    chk("post_rst_instr", ifid_instr, 32'h0050_0093);
    step(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
